rep_add_mult: RTL and testbench
===============================

REP_ADD_MULT -- requirements
Module: rep_add_mult

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port start  input  1: request a new multiply; sampled only in IDLE.
REQ-005 Port a_in  input  WIDTH: multiplicand; captured on the accepted start edge.
REQ-006 Port b_in  input  WIDTH: multiplier; captured on the accepted start edge.
REQ-007 Port product  output  2*WIDTH: registered result; holds its value until the next accepted start.
REQ-008 Port busy  output  1: high in states ADD and DONE.
REQ-009 Port done  output  1: one-cycle pulse, high only in state DONE.

Function
REQ-010 FSM states: IDLE, ADD, DONE, encoded in a registered state vector with no latches; every output is driven in every state.
REQ-011 IDLE with start=1: on that edge, load the addend register A and the count register C, and clear product to 0.
REQ-012 In the same IDLE-with-start edge, go to DONE if C's loaded value is 0, otherwise go to ADD.
REQ-013 IDLE with start=0: remain in IDLE; A, C and product do not change.
REQ-014 ADD, each cycle: product <= product + A, zero-extended to 2*WIDTH; C <= C - 1.
REQ-015 ADD exit: if C==1 at the edge, go to DONE; otherwise remain in ADD.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 Latency: with iteration count N, done is high in the (N+1)th cycle after the accepted start edge; for N=0 it is the 1st cycle.
REQ-018 Arithmetic: product width 2*WIDTH; no overflow is possible; no saturation or wrap logic exists.
REQ-019 start while busy=1 is ignored: no re-capture, no restart, no queuing.
REQ-020 start held high continuously: a new operation is accepted on the IDLE cycle after each DONE, i.e. back-to-back operations separated by one IDLE cycle.
REQ-021 a_in and b_in may change freely after the accepted start edge; the result uses only the captured values.
REQ-022 product is valid from the DONE cycle until the edge of the next accepted start.

Reset
REQ-023 rst=1 at a rising edge: state <= IDLE, product <= 0, A <= 0, C <= 0; busy=0 and done=0 from the following cycle.
REQ-024 rst takes priority over start and over any in-progress operation; a multiply aborted mid-ADD produces no done pulse.
REQ-025 rst and start high on the same edge: reset wins and start is not accepted.

Configuration
REQ-026 Macro REP_ADD_MULT_SWAP_MIN_EN controls operand selection at the accepted start edge.
REQ-027 When REP_ADD_MULT_SWAP_MIN_EN is defined: A <= max(a_in, b_in) and C <= min(a_in, b_in), so N = min(a_in, b_in); if the operands are equal, either assignment is acceptable.
REQ-028 When REP_ADD_MULT_SWAP_MIN_EN is not defined: A <= a_in and C <= b_in, so N = b_in.
REQ-029 The product value is identical in both configurations; only latency differs.

Verification
REQ-030 WIDTH=8, a=3, b=5, one-cycle start: product=15 with done in cycle 6 (swap off) or cycle 4 (swap on); busy high from cycle 1 through the done cycle.
REQ-031 a=200, b=0, and separately a=0, b=200: product=0; done in cycle 1 for a=200/b=0 in both configs; for a=0/b=200, done in cycle 201 (swap off) or cycle 1 (swap on).
REQ-032 a=255, b=255: product=65025 (0xFE01), done in cycle 256 in both configs, with no wrap of product.
REQ-033 a=4, b=6, pulse start=1 again during cycles 2-4 with a=9, b=9: product=24 and exactly one done pulse; the start pulses during busy are ignored.
REQ-034 a=10, b=10, assert rst in cycle 5: busy=0, done=0 and product=0 after the reset edge, no done pulse occurs, and a subsequent 2x3 gives 6.
REQ-035 start held high with operands 2x2, then 3x1: done pulses for 4 and then 3, with exactly one IDLE cycle between DONE and the next busy.

Source files
------------

// File: rtl/rep_add_mult.sv
// Sequential multiplier: product = A * C built by repeated addition of A, C cycles.
// Define REP_ADD_MULT_SWAP_MIN_EN to iterate over the smaller operand (shorter latency).
module rep_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] c_reg;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] c_sel;
    logic             load;

    // Operand selection applied on the accepted start edge.
`ifdef REP_ADD_MULT_SWAP_MIN_EN
    always_comb begin
        if (a_in >= b_in) begin
            a_sel = a_in;
            c_sel = b_in;
        end else begin
            a_sel = b_in;
            c_sel = a_in;
        end
    end
`else
    always_comb begin
        a_sel = a_in;
        c_sel = b_in;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (c_sel == '0) ? DONE : ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (c_reg == WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: load and clear on accept, accumulate while in ADD, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            c_reg   <= '0;
            product <= '0;
        end else if (load) begin
            a_reg   <= a_sel;
            c_reg   <= c_sel;
            product <= '0;
        end else if (state == ADD) begin
            product <= product + {{WIDTH{1'b0}}, a_reg};
            c_reg   <= c_reg - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rep_add_mult.sv
// Self-checking bench for rep_add_mult: directed latency/product cases plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_rep_add_mult;

    localparam int WIDTH = 8;
`ifdef REP_ADD_MULT_SWAP_MIN_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    rep_add_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op lasts N+1 cycles (done in the last),
    // N = b, or min(a,b) when swapping; result is a*b.
    bit m_known  = 1'b0;
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_n      = 0;
    int m_prod   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_prod   = 0;
        end else if (m_known) begin
            if (m_active) begin
                if (m_k == m_n + 1) m_active = 1'b0;
                else m_k++;
            end else if (start) begin
                m_active = 1'b1;
                m_k      = 1;
                m_n      = SWAP ? ((int'(a_in) < int'(b_in)) ? int'(a_in) : int'(b_in)) : int'(b_in);
                m_prod   = int'(a_in) * int'(b_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("busy", 32'(busy), 32'(m_active));
            check("done", 32'(done), 32'(m_active && m_k == m_n + 1));
            if (!m_active || m_k == m_n + 1)
                check("product", 32'(product), 32'(m_prod));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One-cycle start; optional extra start pulses (9x9) during cycles 2..4.
    task automatic run_op(input string name, input int a, input int b, input bit poke,
                          input int exp_prod, input int exp_lat);
        int cyc;
        int lat;
        int dones;
        int prod_at_done;
        @(posedge clk); #1;
        start = 1'b1; a_in = WIDTH'(a); b_in = WIDTH'(b);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; lat = 0; dones = 0; prod_at_done = -1;
        while (cyc <= 400) begin
            if (poke && cyc >= 2 && cyc <= 4) begin
                start = 1'b1; a_in = 9; b_in = 9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                if (lat == 0) begin
                    lat = cyc;
                    prod_at_done = int'(product);
                end
            end
            if (lat != 0 && !busy) break;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " product"}, 32'(prod_at_done), 32'(exp_prod));
        check({name, " done count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        int cyc;
        int dones;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);

        run_op("3x5", 3, 5, 1'b0, 15, SWAP ? 4 : 6);
        run_op("200x0", 200, 0, 1'b0, 0, 1);
        run_op("0x200", 0, 200, 1'b0, 0, SWAP ? 1 : 201);
        run_op("255x255", 255, 255, 1'b0, 65025, 256);
        run_op("4x6 ignore", 4, 6, 1'b1, 24, SWAP ? 5 : 7);

        // Abort a 10x10 with reset asserted in cycle 5.
        @(posedge clk); #1;
        start = 1'b1; a_in = 10; b_in = 10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'd0);
        dones = 0;
        repeat (20) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("abort no done", 32'(dones), 32'd0);
        run_op("2x3 after abort", 2, 3, 1'b0, 6, SWAP ? 3 : 4);

        // start held high: 2x2 then 3x1, one IDLE cycle between.
        @(posedge clk); #1;
        start = 1'b1; a_in = 2; b_in = 2;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 50);
        check("held 2x2 done", 32'(done), 32'd1);
        check("held 2x2 product", 32'(product), 32'd4);
        a_in = 3; b_in = 1;
        @(posedge clk); #1;
        check("held idle gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("held restart busy", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 50) begin @(posedge clk); #1; cyc++; end
        start = 1'b0;
        check("held 3x1 done", 32'(done), 32'd1);
        check("held 3x1 product", 32'(product), 32'd3);
        @(posedge clk); #1;

        // Random traffic, checked every cycle by the model compare process.
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            a_in  = WIDTH'($urandom_range(0, 255));
            b_in  = WIDTH'($urandom_range(0, 12));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
